uart_tx: RTL and testbench

- Serial transmitter: takes a parallel word and shifts it out on a single line as an asynchronous frame (start bit, data LSB first, optional parity, stop bit).
- Built entirely from D flip-flops, a bit counter and a baud-tick counter.
- Drives the line that the team's serial receiver samples; used in lab top-levels and as a stimulus source in receiver benches.

---
 rtl/uart_tx_if.sv | 26 ++
 rtl/uart_tx.sv | 171 +++++++++++++++++
 tb/tb_uart_tx.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - request/word in, serial line and status out, for uart_tx
interface uart_tx_if #(
  parameter int DATA_BITS = 8
);
  logic                 start;
  logic [DATA_BITS-1:0] data;
  logic                 tx;
  logic                 busy;
  logic                 done;

  modport master (
    output start,
    output data,
    input  tx,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  data,
    output tx,
    output busy,
    output done
  );
endinterface

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - serial frame transmitter: start, data LSB first, stop bit
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic     clk,
  input  logic     reset,
  uart_tx_if.slave s
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t               state,     state_n;
  logic [BAUD_W-1:0]    baud_cnt,  baud_n;
  logic [BIT_W-1:0]     bit_cnt,   bit_n;
  logic [DATA_BITS-1:0] shift_reg, shift_n;
  logic                 tx_r,      tx_n;
  logic                 busy_r,    busy_n;
  logic                 done_r,    done_n;
`ifdef UART_TX_PARITY_EN
  logic                 parity_r,  parity_n;
`endif

  logic              baud_wrap;
  logic [BAUD_W-1:0] baud_inc;
  logic              accept;

  assign baud_wrap = (baud_cnt == BAUD_LAST);
  assign baud_inc  = baud_wrap ? '0 : baud_cnt + BAUD_W'(1);

  // A request is taken when idle, or on the very edge that ends the stop bit
  // so back-to-back frames leave no idle gap.
  assign accept = s.start && ((state == S_IDLE) || ((state == S_STOP) && baud_wrap));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      tx_r      <= 1'b1;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_r  <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      baud_cnt  <= baud_n;
      bit_cnt   <= bit_n;
      shift_reg <= shift_n;
      tx_r      <= tx_n;
      busy_r    <= busy_n;
      done_r    <= done_n;
`ifdef UART_TX_PARITY_EN
      parity_r  <= parity_n;
`endif
    end
  end

  always_comb begin
    state_n  = state;
    baud_n   = baud_cnt;
    bit_n    = bit_cnt;
    shift_n  = shift_reg;
    tx_n     = tx_r;
    busy_n   = busy_r;
    done_n   = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_n = parity_r;
`endif

    case (state)
      S_IDLE: begin
        tx_n   = 1'b1;
        busy_n = 1'b0;
        baud_n = '0;
        bit_n  = '0;
      end

      S_START: begin
        baud_n = baud_inc;
        if (baud_wrap) begin
          state_n = S_DATA;
          tx_n    = shift_reg[0];
          bit_n   = '0;
        end
      end

      S_DATA: begin
        baud_n = baud_inc;
        if (baud_wrap) begin
          if (bit_cnt == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_n = S_PARITY;
            tx_n    = parity_r;
`else
            state_n = S_STOP;
            tx_n    = 1'b1;
`endif
          end else begin
            // Next bit goes out from the same edge that shifts it into bit 0.
            shift_n = shift_reg >> 1;
            tx_n    = shift_reg[1];
            bit_n   = bit_cnt + BIT_W'(1);
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        baud_n = baud_inc;
        if (baud_wrap) begin
          state_n = S_STOP;
          tx_n    = 1'b1;
        end
      end
`endif

      S_STOP: begin
        baud_n = baud_inc;
        if (baud_wrap) begin
          state_n = S_IDLE;
          tx_n    = 1'b1;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          bit_n   = '0;
        end
      end

      default: begin
        state_n = S_IDLE;
        tx_n    = 1'b1;
        busy_n  = 1'b0;
        baud_n  = '0;
        bit_n   = '0;
      end
    endcase

    if (accept) begin
      state_n  = S_START;
      shift_n  = s.data;
      tx_n     = 1'b0;
      busy_n   = 1'b1;
      baud_n   = '0;
      bit_n    = '0;
`ifdef UART_TX_PARITY_EN
      parity_n = ^s.data;
`endif
    end
  end

  assign s.tx   = tx_r;
  assign s.busy = busy_r;
  assign s.done = done_r;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - scoreboard bench for uart_tx at 4 and 1 clocks per bit
// Parity expectations follow UART_TX_PARITY_EN when the bench is built with it.
module tb_uart_tx;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  uart_tx_if #(.DATA_BITS(8)) if0 ();
  uart_tx_if #(.DATA_BITS(8)) if1 ();

  uart_tx #(.DATA_BITS(8), .CLKS_PER_BIT(4)) dut0 (
    .clk   (clk),
    .reset (reset),
    .s     (if0.slave)
  );

  uart_tx #(.DATA_BITS(8), .CLKS_PER_BIT(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .s     (if1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic tx;
    logic busy;
    logic done;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected per-cycle line/status for one frame built from the data word.
  task automatic push_frame(input logic [7:0] d, input int cpb, input bit chained);
    logic bits[$];
    exp_t e;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
    bits.push_back(^d);
`endif
    bits.push_back(1'b1);
    for (int b = 0; b < bits.size(); b++) begin
      for (int c = 0; c < cpb; c++) begin
        e.tx   = bits[b];
        e.busy = 1'b1;
        e.done = chained && (b == 0) && (c == 0);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic push_idle(input int n, input bit done_first);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.tx   = 1'b1;
      e.busy = 1'b0;
      e.done = done_first && (i == 0);
      exp_q.push_back(e);
    end
  endtask

  task automatic drain(input int sel);
    exp_t e;
    int   n;
    n = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      if (sel == 0) begin
        chk($sformatf("dut0.tx[%0d]", n),   if0.tx,   e.tx);
        chk($sformatf("dut0.busy[%0d]", n), if0.busy, e.busy);
        chk($sformatf("dut0.done[%0d]", n), if0.done, e.done);
      end else begin
        chk($sformatf("dut1.tx[%0d]", n),   if1.tx,   e.tx);
        chk($sformatf("dut1.busy[%0d]", n), if1.busy, e.busy);
        chk($sformatf("dut1.done[%0d]", n), if1.done, e.done);
      end
      n++;
    end
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    reset     = 1'b1;
    if0.start = 1'b0;
    if0.data  = '0;
    if1.start = 1'b0;
    if1.data  = '0;

    #1;
    chk("reset.tx",   if0.tx,   1'b1);
    chk("reset.busy", if0.busy, 1'b0);
    chk("reset.done", if0.done, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    push_idle(2, 1'b0);
    drain(0);

    // Single frame 8'hA5, start pulsed for one cycle.
    if0.start = 1'b1;
    if0.data  = 8'hA5;
    push_frame(8'hA5, 4, 1'b0);
    push_idle(3, 1'b1);
    @(posedge clk);
    #1 if0.start = 1'b0;
    drain(0);

    // start held high: 8'h00 then 8'hFF back to back.
    if0.start = 1'b1;
    if0.data  = 8'h00;
    push_frame(8'h00, 4, 1'b0);
    push_frame(8'hFF, 4, 1'b1);
    push_idle(2, 1'b1);
    @(posedge clk);
    #1 if0.data = 8'hFF;
    fork
      drain(0);
      begin
        repeat (45) @(posedge clk);
        #1 if0.start = 1'b0;
      end
    join

    // start and data poked mid-frame must not disturb or queue a frame.
    if0.start = 1'b1;
    if0.data  = 8'h3C;
    push_frame(8'h3C, 4, 1'b0);
    push_idle(4, 1'b1);
    @(posedge clk);
    #1 if0.start = 1'b0;
    fork
      drain(0);
      begin
        repeat (9) @(posedge clk);
        #1;
        if0.start = 1'b1;
        if0.data  = 8'hC3;
        @(posedge clk);
        #1 if0.start = 1'b0;
      end
    join

    // Asynchronous reset in the middle of data bit 3.
    if0.start = 1'b1;
    if0.data  = 8'h00;
    @(posedge clk);
    #1 if0.start = 1'b0;
    repeat (16) @(posedge clk);
    #3;
    chk("pre_reset.tx",   if0.tx,   1'b0);
    chk("pre_reset.busy", if0.busy, 1'b1);
    reset = 1'b1;
    #1;
    chk("async_reset.tx",   if0.tx,   1'b1);
    chk("async_reset.busy", if0.busy, 1'b0);
    chk("async_reset.done", if0.done, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    push_idle(6, 1'b0);
    drain(0);

    // One clock per bit.
    if1.start = 1'b1;
    if1.data  = 8'h81;
    push_frame(8'h81, 1, 1'b0);
    push_idle(3, 1'b1);
    @(posedge clk);
    #1 if1.start = 1'b0;
    drain(1);

    // Frames whose parity bit differs when parity is built in.
    if0.start = 1'b1;
    if0.data  = 8'h07;
    push_frame(8'h07, 4, 1'b0);
    push_idle(2, 1'b1);
    @(posedge clk);
    #1 if0.start = 1'b0;
    drain(0);

    if0.start = 1'b1;
    if0.data  = 8'h03;
    push_frame(8'h03, 4, 1'b0);
    push_idle(2, 1'b1);
    @(posedge clk);
    #1 if0.start = 1'b0;
    drain(0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
